// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage operation at a time, passes
// non-memory results straight to writeback, and runs a single data memory access.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [7:0]  ex_op,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    localparam logic [7:0] ALU_OPERATIONS_NOP  = 8'h00;
    localparam logic [7:0] ALU_OPERATIONS_ADD  = 8'h01;
    localparam logic [7:0] ALU_OPERATIONS_SUB  = 8'h02;
    localparam logic [7:0] ALU_OPERATIONS_AND  = 8'h03;
    localparam logic [7:0] ALU_OPERATIONS_OR   = 8'h04;
    localparam logic [7:0] ALU_OPERATIONS_XOR  = 8'h05;
    localparam logic [7:0] ALU_OPERATIONS_SLL  = 8'h06;
    localparam logic [7:0] ALU_OPERATIONS_SRL  = 8'h07;
    localparam logic [7:0] ALU_OPERATIONS_SRA  = 8'h08;
    localparam logic [7:0] ALU_OPERATIONS_SLT  = 8'h09;
    localparam logic [7:0] ALU_OPERATIONS_SLTU = 8'h0A;
    localparam logic [7:0] ALU_OPERATIONS_LB   = 8'h10;
    localparam logic [7:0] ALU_OPERATIONS_LH   = 8'h11;
    localparam logic [7:0] ALU_OPERATIONS_LW   = 8'h12;
    localparam logic [7:0] ALU_OPERATIONS_LBU  = 8'h13;
    localparam logic [7:0] ALU_OPERATIONS_LHU  = 8'h14;
    localparam logic [7:0] ALU_OPERATIONS_SB   = 8'h18;
    localparam logic [7:0] ALU_OPERATIONS_SH   = 8'h19;
    localparam logic [7:0] ALU_OPERATIONS_SW   = 8'h1A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    state_e      state;
    size_e       size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic        dec_load;
    logic        dec_store;
    logic        dec_uns;
    size_e       dec_size;
    logic        dec_aligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign ex_ready = (state == S_IDLE);

    always_comb begin
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_uns   = 1'b0;
        dec_size  = SZ_W;
        case (ex_op)
            ALU_OPERATIONS_LB:  begin dec_load  = 1'b1; dec_size = SZ_B; end
            ALU_OPERATIONS_LBU: begin dec_load  = 1'b1; dec_size = SZ_B; dec_uns = 1'b1; end
            ALU_OPERATIONS_LH:  begin dec_load  = 1'b1; dec_size = SZ_H; end
            ALU_OPERATIONS_LHU: begin dec_load  = 1'b1; dec_size = SZ_H; dec_uns = 1'b1; end
            ALU_OPERATIONS_LW:  begin dec_load  = 1'b1; dec_size = SZ_W; end
            ALU_OPERATIONS_SB:  begin dec_store = 1'b1; dec_size = SZ_B; end
            ALU_OPERATIONS_SH:  begin dec_store = 1'b1; dec_size = SZ_H; end
            ALU_OPERATIONS_SW:  begin dec_store = 1'b1; dec_size = SZ_W; end
            default: ;
        endcase
    end

    always_comb begin
        dec_aligned = 1'b1;
        req_be      = 4'b1111;
        req_wdata   = ex_store_data;
        case (dec_size)
            SZ_B: begin
                req_be    = 4'b0001 << ex_result[1:0];
                req_wdata = {4{ex_store_data[7:0]}};
            end
            SZ_H: begin
                dec_aligned = ~ex_result[0];
                req_be      = ex_result[1] ? 4'b1100 : 4'b0011;
                req_wdata   = {2{ex_store_data[15:0]}};
            end
            default: dec_aligned = (ex_result[1:0] == 2'b00);
        endcase
    end

    // Lane selection uses the offset captured at accept time, not the live bus.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SZ_B:    ld_data = uns_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = uns_q ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            size_q     <= SZ_W;
            uns_q      <= 1'b0;
            off_q      <= '0;
            rd_q       <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            misaligned <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!(dec_load || dec_store)) begin
                            wb_valid <= 1'b1;
                            wb_we    <= (ex_rd != '0) && (ex_op != ALU_OPERATIONS_NOP);
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_result;
                        end else if (!dec_aligned) begin
                            wb_valid   <= 1'b1;
                            misaligned <= 1'b1;
                            wb_rd      <= ex_rd;
                            wb_data    <= ex_result;
                        end else begin
                            state      <= S_REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= dec_store;
                            dmem_addr  <= {ex_result[31:2], 2'b00};
                            dmem_be    <= req_be;
                            dmem_wdata <= dec_store ? req_wdata : '0;
                            size_q     <= dec_size;
                            uns_q      <= dec_uns;
                            off_q      <= ex_result[1:0];
                            rd_q       <= ex_rd;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            state    <= S_IDLE;
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b1;
                        wb_we    <= (rd_q != '0);
                        wb_rd    <= rd_q;
                        wb_data  <= ld_data;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: random operation stream against a byte-lane memory
// model, plus directed cases for holding, misalignment and mid-transaction reset.
module tb_lsu;

    localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_AND = 8'h03,
                           OP_OR  = 8'h04, OP_XOR = 8'h05, OP_SLL = 8'h06, OP_SRL = 8'h07,
                           OP_SRA = 8'h08, OP_SLT = 8'h09, OP_SLTU = 8'h0A,
                           OP_LB  = 8'h10, OP_LH  = 8'h11, OP_LW  = 8'h12, OP_LBU = 8'h13,
                           OP_LHU = 8'h14, OP_SB  = 8'h18, OP_SH  = 8'h19, OP_SW  = 8'h1A;

    logic        clk, rst_n;
    logic        ex_valid, ex_ready;
    logic [7:0]  ex_op;
    logic [31:0] ex_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_we, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        directed;
    logic        d_gnt, d_rvalid, r_gnt, r_rvalid;
    logic [31:0] d_rdata, r_rdata;

    assign dmem_gnt    = directed ? d_gnt    : r_gnt;
    assign dmem_rvalid = directed ? d_rvalid : r_rvalid;
    assign dmem_rdata  = directed ? d_rdata  : r_rdata;

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chk_data;
        bit          mis;
    } wb_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    wb_t         exp_wb[$];
    mem_t        exp_mem[$];
    logic [31:0] rdata_q[$];

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned wb_seen = 0;

    // ---------------- reference model ----------------
    function automatic int unsigned access_bytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_store_op(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic bit is_unsigned_op(input logic [7:0] op);
        return (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned n   = access_bytes(op);
        int unsigned off = addr % 4;
        logic [31:0] v   = word >> (8 * off);
        if (n == 1) v = is_unsigned_op(op) ? (v & 32'hFF) : ((v & 32'h80) != 0 ? (v | 32'hFFFF_FF00) : (v & 32'hFF));
        if (n == 2) v = is_unsigned_op(op) ? (v & 32'hFFFF) : ((v & 32'h8000) != 0 ? (v | 32'hFFFF_0000) : (v & 32'hFFFF));
        return v;
    endfunction

    function automatic logic [3:0] model_be(input int unsigned n, input logic [31:0] addr);
        logic [3:0] be = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (i >= addr % 4 && i < addr % 4 + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input int unsigned n, input logic [31:0] d);
        logic [31:0] w = '0;
        for (int unsigned i = 0; i < 4; i++)
            w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    // ---------------- stimulus ----------------
    task automatic issue(input logic [7:0] op, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [31:0] rdata, input bit push_wb);
        int unsigned n = access_bytes(op);
        int unsigned t = 0;
        wb_t  w;
        mem_t m;
        w.rd = rd; w.data = res; w.we = 1'b0; w.chk_data = 1'b0; w.mis = 1'b0;
        if (n == 0) begin
            w.we = (rd != 0) && (op != OP_NOP);
            w.chk_data = 1'b1;
        end else if (res % n != 0) begin
            w.mis = 1'b1;
        end else begin
            m.we    = is_store_op(op);
            m.addr  = res & 32'hFFFF_FFFC;
            m.be    = model_be(n, res);
            m.wdata = model_wdata(n, sd);
            exp_mem.push_back(m);
            if (!m.we) begin
                w.we = (rd != 0);
                w.data = model_load(op, res, rdata);
                w.chk_data = 1'b1;
                if (push_wb) rdata_q.push_back(rdata);
            end
        end
        if (push_wb) exp_wb.push_back(w);
        ex_valid = 1'b1; ex_op = op; ex_result = res; ex_store_data = sd; ex_rd = rd;
        while (!ex_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ex_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: ex_ready=%0b after %0d cycles, required 1", ex_ready, t);
        end
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((exp_wb.size() != 0 || exp_mem.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_wb.size() != 0 || exp_mem.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending wb=%0d mem=%0d, required 0/0", exp_wb.size(), exp_mem.size());
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        r_gnt = 1'b0; r_rvalid = 1'b0; r_rdata = '0;
        forever begin
            @(negedge clk);
            r_gnt = 1'b0;
            r_rvalid = 1'b0;
            if (directed || !rst_n) continue;
            if (dmem_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    r_gnt = 1'b1;
                    if (!dmem_we) begin
                        @(negedge clk);
                        r_gnt = 1'b0;
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        r_rvalid = 1'b1;
                        r_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                r_rvalid = 1'b1;
                r_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit   hold = 1'b0;
        mem_t held;
        mem_t m;
        wb_t  w;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                n_cmp++;
                if (!dmem_req || dmem_we != held.we || dmem_addr != held.addr ||
                    dmem_be != held.be || dmem_wdata != held.wdata) begin
                    n_fail++;
                    $display("FAIL req_stable: req=%0b we=%0b addr=%h be=%b wdata=%h, required req=1 we=%0b addr=%h be=%b wdata=%h",
                             dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, held.we, held.addr, held.be, held.wdata);
                end
            end
            if (dmem_req && dmem_gnt) begin
                hold = 1'b0;
                n_cmp++;
                if (exp_mem.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_req: addr=%h we=%0b, required no request", dmem_addr, dmem_we);
                end else begin
                    m = exp_mem.pop_front();
                    if (dmem_we != m.we || dmem_addr != m.addr || dmem_be != m.be ||
                        (m.we && dmem_wdata != m.wdata)) begin
                        n_fail++;
                        $display("FAIL mem_req: we=%0b addr=%h be=%b wdata=%h, required we=%0b addr=%h be=%b wdata=%h",
                                 dmem_we, dmem_addr, dmem_be, dmem_wdata, m.we, m.addr, m.be, m.wdata);
                    end
                end
            end else if (dmem_req) begin
                hold = 1'b1;
                held.we = dmem_we; held.addr = dmem_addr; held.be = dmem_be; held.wdata = dmem_wdata;
            end else begin
                hold = 1'b0;
            end
            if (wb_valid) begin
                wb_seen++;
                n_cmp++;
                if (exp_wb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_wb: rd=%0d data=%h, required no writeback", wb_rd, wb_data);
                end else begin
                    w = exp_wb.pop_front();
                    if (wb_we != w.we || misaligned != w.mis ||
                        ((w.we || w.chk_data) && wb_rd != w.rd) ||
                        (w.chk_data && wb_data != w.data)) begin
                        n_fail++;
                        $display("FAIL writeback: we=%0b mis=%0b rd=%0d data=%h, required we=%0b mis=%0b rd=%0d data=%h",
                                 wb_we, misaligned, wb_rd, wb_data, w.we, w.mis, w.rd, w.data);
                    end
                end
            end else if (misaligned) begin
                n_cmp++;
                n_fail++;
                $display("FAIL mis_pulse: misaligned=1 with wb_valid=0, required both together");
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  op_tab [19];
        logic [7:0]  op;
        logic [31:0] res;
        logic [4:0]  rd;
        int unsigned seen0;

        op_tab = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                   OP_SLT, OP_SLTU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        directed = 1'b0; d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = '0;
        rst_n = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_result = '0; ex_store_data = '0; ex_rd = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (dmem_req || wb_valid || wb_we || misaligned || wb_rd != 0 || wb_data != 0 ||
            dmem_addr != 0 || dmem_be != 0 || dmem_wdata != 0 || !ex_ready) begin
            n_fail++;
            $display("FAIL reset_state: req=%0b wbv=%0b we=%0b mis=%0b rd=%0d data=%h addr=%h be=%b wdata=%h ready=%0b, required zeros and ready=1",
                     dmem_req, wb_valid, wb_we, misaligned, wb_rd, wb_data, dmem_addr, dmem_be, dmem_wdata, ex_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_ADD, 32'h0000_0042, 32'h0, 5'd5, 32'h0, 1'b1);
        issue(OP_ADD, 32'h1234_5678, 32'h0, 5'd0, 32'h0, 1'b1);
        issue(OP_NOP, 32'hDEAD_BEEF, 32'h0, 5'd9, 32'h0, 1'b1);
        drain();

        // Store held three cycles without grant
        directed = 1'b1;
        issue(OP_SB, 32'h0000_1003, 32'h0000_00AB, 5'd4, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        d_gnt = 1'b1;
        @(negedge clk);
        d_gnt = 1'b0;
        directed = 1'b0;
        drain();

        issue(OP_LB,  32'h0000_2001, 32'h0, 5'd7, 32'h0000_8000, 1'b1);
        issue(OP_LBU, 32'h0000_2001, 32'h0, 5'd8, 32'h0000_8000, 1'b1);
        issue(OP_LW,  32'h0000_3002, 32'h0, 5'd6, 32'h0, 1'b1);
        issue(OP_LH,  32'h0000_3006, 32'h0, 5'd3, 32'h8001_7FFF, 1'b1);
        issue(OP_LHU, 32'h0000_3006, 32'h0, 5'd3, 32'h8001_7FFF, 1'b1);
        issue(OP_SH,  32'h0000_3003, 32'h1234_5678, 5'd1, 32'h0, 1'b1);
        drain();

        for (int i = 0; i < 300; i++) begin
            op  = op_tab[$urandom_range(0, 18)];
            res = $urandom;
            if ($urandom_range(0, 1) == 0) res[1:0] = 2'b00;
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue(op, res, $urandom, rd, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        // Reset while a load waits for data; late responses must be dropped
        directed = 1'b1;
        issue(OP_LW, 32'h0000_4000, 32'h0, 5'd3, 32'h0, 1'b0);
        d_gnt = 1'b1;
        @(negedge clk);
        d_gnt = 1'b0;
        seen0 = wb_seen;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dmem_req || wb_valid || misaligned || !ex_ready) begin
            n_fail++;
            $display("FAIL async_reset: req=%0b wbv=%0b mis=%0b ready=%0b, required 0 0 0 1",
                     dmem_req, wb_valid, misaligned, ex_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        d_rvalid = 1'b1; d_gnt = 1'b1; d_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        d_rvalid = 1'b0; d_gnt = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_cmp++;
        if (wb_seen != seen0 || !ex_ready) begin
            n_fail++;
            $display("FAIL late_response: wb pulses=%0d ready=%0b, required 0 and 1", wb_seen - seen0, ex_ready);
        end
        directed = 1'b0;

        issue(OP_ADD, 32'h0000_0077, 32'h0, 5'd2, 32'h0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
